stamp2time: RTL

- Sequential converter from a 64-bit Unix timestamp (seconds since 1970-01-01 00:00:00) to BCD calendar fields: year, month, day, hour, minute and second.
- It is the inverse of the combinational BCD-to-timestamp block.
- Used by the clock to load a stored or externally supplied timestamp into the display/counter registers.
- Iterative datapath: one subtract/compare per cycle, no wide combinational dividers.

---
 rtl/time_pkg.sv | 48 ++++
 rtl/bin2bcd_seq.sv | 76 +++++++
 rtl/stamp2time.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/time_pkg.sv
// Shared calendar constants, FSM encoding and small helpers for the timestamp/BCD blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package time_pkg;

    localparam logic [16:0] SEC_PER_DAY  = 17'd86400;
    localparam logic [16:0] SEC_PER_HOUR = 17'd3600;
    localparam logic [16:0] SEC_PER_MIN  = 17'd60;
    localparam logic [13:0] EPOCH_YEAR   = 14'd1970;
    localparam logic [63:0] MAX_STAMP    = 64'd253402300799;  // 9999-12-31 23:59:59

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_DIV,
        S_HOUR,
        S_MIN,
        S_YEAR,
        S_MONTH,
        S_BCD,
        S_DONE
    } state_t;

    // Days in a month (1..12); February depends on the leap flag.
    function automatic logic [4:0] month_len(input logic [3:0] month, input logic leap);
        case (month)
            4'd2:                    month_len = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
            default:                 month_len = 5'd31;
        endcase
    endfunction

    // Two-digit BCD of a value below 100; tens digit from a constant compare ladder.
    function automatic logic [7:0] to_bcd8(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'd0;
        ones = v[3:0];
        for (int t = 1; t <= 9; t++) begin
            if (v >= 7'(10 * t)) begin
                tens = 4'(t);
                ones = 4'(v - 7'(10 * t));
            end
        end
        to_bcd8 = {tens, ones};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: BIN_W-bit binary to BCD_W-bit packed BCD.
// Latency: BIN_W cycles from start to the done pulse; result holds until the next start.
// Backpressure: none; a start while running restarts the conversion.
// Ports: clk, rst_n (async active-low), start (capture bin_dat), bin_dat, done (1-cycle pulse), bcd_dat.
module bin2bcd_seq #(
    parameter int unsigned BIN_W = 14,
    parameter int unsigned BCD_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_dat,
    output logic             done,
    output logic [BCD_W-1:0] bcd_dat
);

    localparam int unsigned CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic [BCD_W-1:0] adj;
    logic [3:0]       nib;

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        adj    = '0;
        nib    = '0;
        // Add 3 to every digit >= 5 so the following left shift carries correctly.
        for (int i = 0; i < int'(BCD_W / 4); i++) begin
            nib            = bcd_q[4*i +: 4];
            adj[4*i +: 4]  = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        if (start) begin
            bin_d = bin_dat;
            bcd_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            bcd_d = BCD_W'({adj, bin_q[BIN_W-1]});
            bin_d = {bin_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done    = done_q;
    assign bcd_dat = bcd_q;

endmodule

// File: rtl/stamp2time.sv
// Iterative Unix-seconds to BCD calendar converter (year..second), one subtract/compare per cycle.
// Latency: 2 cycles start->done for out-of-range stamps, at most ~8210 cycles otherwise (year loop dominates).
// Backpressure: start is sampled only in IDLE; starts while busy are dropped, nothing is queued.
// Ports: clk, rst_n (async active-low), start, time_stamp -> busy, done (pulse), err, *_bcd fields.
module stamp2time #(
    parameter int unsigned         STAMP_W   = 64,
    parameter logic [STAMP_W-1:0]  MAX_STAMP = STAMP_W'(time_pkg::MAX_STAMP)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [STAMP_W-1:0] time_stamp,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [15:0]        year_bcd,
    output logic [7:0]         month_bcd,
    output logic [7:0]         day_bcd,
    output logic [7:0]         hour_bcd,
    output logic [7:0]         minute_bcd,
    output logic [7:0]         second_bcd
);
    import time_pkg::*;

    localparam int unsigned      CNT_W    = $clog2(STAMP_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAMP_W - 1);

    state_t             state_q, state_d;
    logic [STAMP_W-1:0] stamp_q, stamp_d;   // dividend, becomes the quotient during DIV
    logic [16:0]        rem_q, rem_d;       // division remainder, then seconds-of-day
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [21:0]        days_q, days_d;
    logic [4:0]         hour_q, hour_d;
    logic [5:0]         min_q, min_d;
    logic [5:0]         sec_q, sec_d;
    logic [13:0]        year_q, year_d;
    logic [1:0]         mod4_q, mod4_d;
    logic [6:0]         mod100_q, mod100_d;
    logic [8:0]         mod400_q, mod400_d;
    logic [3:0]         month_q, month_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [15:0]        year_bcd_q, year_bcd_d;
    logic [7:0]         month_bcd_q, month_bcd_d;
    logic [7:0]         day_bcd_q, day_bcd_d;
    logic [7:0]         hour_bcd_q, hour_bcd_d;
    logic [7:0]         minute_bcd_q, minute_bcd_d;
    logic [7:0]         second_bcd_q, second_bcd_d;

    logic               bcd_start;
    logic               bcd_done;
    logic [15:0]        bcd_dat;
    logic [17:0]        div_r;
    logic               div_ge;
    logic [STAMP_W-1:0] div_shift;
    logic               leap;
    logic [8:0]         year_len;
    logic [4:0]         mon_len;

    bin2bcd_seq #(.BIN_W(14), .BCD_W(16)) u_year_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (bcd_start),
        .bin_dat (year_q),
        .done    (bcd_done),
        .bcd_dat (bcd_dat)
    );

    always_comb begin
        state_d      = state_q;
        stamp_d      = stamp_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        days_d       = days_q;
        hour_d       = hour_q;
        min_d        = min_q;
        sec_d        = sec_q;
        year_d       = year_q;
        mod4_d       = mod4_q;
        mod100_d     = mod100_q;
        mod400_d     = mod400_q;
        month_d      = month_q;
        err_d        = err_q;
        year_bcd_d   = year_bcd_q;
        month_bcd_d  = month_bcd_q;
        day_bcd_d    = day_bcd_q;
        hour_bcd_d   = hour_bcd_q;
        minute_bcd_d = minute_bcd_q;
        second_bcd_d = second_bcd_q;
        bcd_start    = 1'b0;

        // Restoring division step: bring in the next dividend bit, subtract if it fits,
        // and shift the quotient bit into the vacated LSB of the dividend register.
        div_r     = {rem_q, stamp_q[STAMP_W-1]};
        div_ge    = (div_r >= {1'b0, SEC_PER_DAY});
        div_shift = {stamp_q[STAMP_W-2:0], div_ge};

        leap     = ((mod4_q == 2'd0) && (mod100_q != 7'd0)) || (mod400_q == 9'd0);
        year_len = leap ? 9'd366 : 9'd365;
        mon_len  = month_len(month_q, leap);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    stamp_d  = time_stamp;
                    err_d    = 1'b0;
                    rem_d    = '0;
                    cnt_d    = '0;
                    days_d   = '0;
                    hour_d   = '0;
                    min_d    = '0;
                    sec_d    = '0;
                    year_d   = EPOCH_YEAR;
                    mod4_d   = 2'd2;     // 1970 mod 4
                    mod100_d = 7'd70;    // 1970 mod 100
                    mod400_d = 9'd370;   // 1970 mod 400
                    month_d  = 4'd1;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (stamp_q > MAX_STAMP) begin
                    err_d        = 1'b1;
                    year_bcd_d   = 16'h1970;
                    month_bcd_d  = 8'h01;
                    day_bcd_d    = 8'h01;
                    hour_bcd_d   = 8'h00;
                    minute_bcd_d = 8'h00;
                    second_bcd_d = 8'h00;
                    state_d      = S_DONE;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                stamp_d = div_shift;
                rem_d   = div_ge ? 17'(div_r - {1'b0, SEC_PER_DAY}) : div_r[16:0];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    days_d  = div_shift[21:0];  // in-range stamps never exceed 22 bits of days
                    state_d = S_HOUR;
                end
            end
            S_HOUR: begin
                if (rem_q >= SEC_PER_HOUR) begin
                    rem_d  = rem_q - SEC_PER_HOUR;
                    hour_d = hour_q + 5'd1;
                end else begin
                    state_d = S_MIN;
                end
            end
            S_MIN: begin
                if (rem_q >= SEC_PER_MIN) begin
                    rem_d = rem_q - SEC_PER_MIN;
                    min_d = min_q + 6'd1;
                end else begin
                    sec_d   = rem_q[5:0];
                    state_d = S_YEAR;
                end
            end
            S_YEAR: begin
                if (days_q >= {13'd0, year_len}) begin
                    days_d   = days_q - {13'd0, year_len};
                    year_d   = year_q + 14'd1;
                    mod4_d   = mod4_q + 2'd1;
                    mod100_d = (mod100_q == 7'd99)  ? 7'd0 : mod100_q + 7'd1;
                    mod400_d = (mod400_q == 9'd399) ? 9'd0 : mod400_q + 9'd1;
                end else begin
                    state_d = S_MONTH;
                end
            end
            S_MONTH: begin
                if (days_q >= {17'd0, mon_len}) begin
                    days_d  = days_q - {17'd0, mon_len};
                    month_d = month_q + 4'd1;
                end else begin
                    bcd_start = 1'b1;   // year_q is final from here on
                    state_d   = S_BCD;
                end
            end
            S_BCD: begin
                if (bcd_done) begin
                    year_bcd_d   = bcd_dat;
                    month_bcd_d  = to_bcd8(7'(month_q));
                    day_bcd_d    = to_bcd8(7'(days_q[4:0]) + 7'd1);
                    hour_bcd_d   = to_bcd8(7'(hour_q));
                    minute_bcd_d = to_bcd8(7'(min_q));
                    second_bcd_d = to_bcd8(7'(sec_q));
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            stamp_q      <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            days_q       <= '0;
            hour_q       <= '0;
            min_q        <= '0;
            sec_q        <= '0;
            year_q       <= '0;
            mod4_q       <= '0;
            mod100_q     <= '0;
            mod400_q     <= '0;
            month_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            year_bcd_q   <= 16'h1970;
            month_bcd_q  <= 8'h01;
            day_bcd_q    <= 8'h01;
            hour_bcd_q   <= 8'h00;
            minute_bcd_q <= 8'h00;
            second_bcd_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            stamp_q      <= stamp_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            days_q       <= days_d;
            hour_q       <= hour_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            year_q       <= year_d;
            mod4_q       <= mod4_d;
            mod100_q     <= mod100_d;
            mod400_q     <= mod400_d;
            month_q      <= month_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            year_bcd_q   <= year_bcd_d;
            month_bcd_q  <= month_bcd_d;
            day_bcd_q    <= day_bcd_d;
            hour_bcd_q   <= hour_bcd_d;
            minute_bcd_q <= minute_bcd_d;
            second_bcd_q <= second_bcd_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign year_bcd   = year_bcd_q;
    assign month_bcd  = month_bcd_q;
    assign day_bcd    = day_bcd_q;
    assign hour_bcd   = hour_bcd_q;
    assign minute_bcd = minute_bcd_q;
    assign second_bcd = second_bcd_q;

endmodule
